// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch controller.
//   fetch_state_t : IDLE / FETCH / SQUASH / WAIT controller states
//   PC_INC        : sequential PC step (16-bit LC-3b instructions, byte addressed)
//   RESET_PC_DEF  : default reset PC
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SQUASH, WAIT} fetch_state_t;

  localparam int unsigned PC_INC       = 2;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: 16-bit event counter that sticks at 16'hFFFF.
//   clk     : clock, rising edge
//   reset   : asynchronous active-high clear
//   inc_i   : count one event this cycle
//   count_o : current count
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [15:0] count_o
);
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             cnt_q <= '0;
    else if (inc_i && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC owner and fetch sequencer with a one-entry IF/ID buffer.
//   clk, reset            : clock; asynchronous active-high reset
//   i_mem_read/_address   : instruction read request, address held until resp
//   i_mem_resp/_rdata     : one-cycle completion pulse and instruction word
//   dcache_stall/ldi_stall: downstream stalls; buffered instr held while set
//   br_taken/br_target    : one-cycle redirect
//   if_id_valid/_instr/_pc: IF/ID buffer contents
// Optional build macro FETCH_PERF_EN adds fetch_count (instructions consumed)
// and squash_count (responses discarded), both saturating 16-bit.
module if_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              i_mem_read,
  output logic [ADDR_W-1:0] i_mem_address,
  input  logic              i_mem_resp,
  input  logic [ADDR_W-1:0] i_mem_rdata,
  input  logic              dcache_stall,
  input  logic              ldi_stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_id_valid,
  output logic [ADDR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       squash_count
`endif
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_q, req_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] bpc_q, bpc_d;
  logic              stall;

  assign stall = dcache_stall | ldi_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= RESET_PC;
      instr_q <= '0;
      bpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      bpc_q   <= bpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    instr_d = instr_q;
    bpc_d   = bpc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (br_taken) begin
          pc_d  = br_target;
          req_d = br_target;
        end else begin
          req_d = pc_q;
        end
      end
      FETCH: begin
        if (i_mem_resp && br_taken) begin
          // data belongs to the old path; refetch at the target right away
          pc_d  = br_target;
          req_d = br_target;
        end else if (i_mem_resp) begin
          instr_d = i_mem_rdata;
          bpc_d   = req_q;
          pc_d    = req_q + ADDR_W'(PC_INC);
          state_d = WAIT;
        end else if (br_taken) begin
          // the memory cannot be cancelled: ride out the old request
          pc_d    = br_target;
          state_d = SQUASH;
        end
      end
      SQUASH: begin
        if (br_taken) pc_d = br_target;
        if (i_mem_resp) begin
          req_d   = br_taken ? br_target : pc_q;
          state_d = FETCH;
        end
      end
      WAIT: begin
        if (br_taken) begin
          pc_d    = br_target;
          req_d   = br_target;
          state_d = FETCH;
        end else if (!stall) begin
          req_d   = pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_mem_read    = (state_q == FETCH) || (state_q == SQUASH);
  assign i_mem_address = req_q;
  assign if_id_valid   = (state_q == WAIT);
  assign if_id_instr   = instr_q;
  assign if_id_pc      = bpc_q;

`ifdef FETCH_PERF_EN
  logic consume, discard;
  assign consume = (state_q == WAIT) && !stall;
  assign discard = i_mem_resp &&
                   ((state_q == SQUASH) || ((state_q == FETCH) && br_taken));

  fetch_perf_ctr u_fetch_ctr (
    .clk(clk), .reset(reset), .inc_i(consume), .count_o(fetch_count)
  );
  fetch_perf_ctr u_squash_ctr (
    .clk(clk), .reset(reset), .inc_i(discard), .count_o(squash_count)
  );
`endif
endmodule
